// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational 32-bit integer ALU for the execute stage of a MIPS-style
// datapath, plus a registered copy of its result for stage boundaries.
//
// Ports:
//   clk_i       - system clock, rising edge updates the registered copies
//   rst_n_i     - asynchronous active-low reset, clears the registered copies
//   aluop_i     - 5-bit operation select
//   src0_i      - operand A (rs); shift amount for shifts, dividend for divides
//   src1_i      - operand B (rt / immediate); value shifted for shifts
//   aluout_o    - combinational 64-bit result, [63:32]=hi, [31:0]=lo
//   zero_o      - combinational, high when aluout_o[31:0] is zero
//   aluout_r_o  - aluout_o captured on each rising clk_i
//   zero_r_o    - zero_o captured on each rising clk_i
// ---------------------------------------------------------------------------
module alu (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  aluop_i,
  input  logic [31:0] src0_i,
  input  logic [31:0] src1_i,
  output logic [63:0] aluout_o,
  output logic        zero_o,
  output logic [63:0] aluout_r_o,
  output logic        zero_r_o
);

  localparam logic [4:0] ALUOP_NOP   = 5'd0;
  localparam logic [4:0] ALUOP_ADD   = 5'd1;
  localparam logic [4:0] ALUOP_SUB   = 5'd2;
  localparam logic [4:0] ALUOP_SLT   = 5'd3;
  localparam logic [4:0] ALUOP_SLTU  = 5'd4;
  localparam logic [4:0] ALUOP_AND   = 5'd5;
  localparam logic [4:0] ALUOP_NOR   = 5'd6;
  localparam logic [4:0] ALUOP_OR    = 5'd7;
  localparam logic [4:0] ALUOP_LUI   = 5'd8;
  localparam logic [4:0] ALUOP_SLL   = 5'd9;
  localparam logic [4:0] ALUOP_SRL   = 5'd10;
  localparam logic [4:0] ALUOP_SRA   = 5'd11;
  localparam logic [4:0] ALUOP_MULT  = 5'd12;
  localparam logic [4:0] ALUOP_MULTU = 5'd13;
  localparam logic [4:0] ALUOP_DIV   = 5'd14;
  localparam logic [4:0] ALUOP_DIVU  = 5'd15;

  logic [4:0]  w_shamt;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_sra;
  logic        w_slt;
  logic        w_sltu;
  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic        w_divZero;
  logic [31:0] w_divisor;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [31:0] w_magQ;
  logic [31:0] w_magR;
  logic [31:0] w_sQuot;
  logic [31:0] w_sRem;
  logic [31:0] w_uQuot;
  logic [31:0] w_uRem;
  logic [63:0] w_result;

  // Shared arithmetic terms. Only the low five bits of src0 set a shift.
  assign w_shamt = src0_i[4:0];
  assign w_sum   = src0_i + src1_i;
  assign w_diff  = src0_i - src1_i;
  assign w_sra   = $signed(src1_i) >>> w_shamt;
  assign w_slt   = $signed(src0_i) < $signed(src1_i);
  assign w_sltu  = src0_i < src1_i;

  // Sign-extending both operands to 64 bits gives the exact signed product.
  assign w_sprod = {{32{src0_i[31]}}, src0_i} * {{32{src1_i[31]}}, src1_i};
  assign w_uprod = {32'b0, src0_i} * {32'b0, src1_i};

  // A zero divisor is replaced by 1 so the dividers never produce X; the
  // divide-by-zero result is substituted afterwards.
  assign w_divZero = (src1_i == 32'b0);
  assign w_divisor = w_divZero ? 32'd1 : src1_i;

  // Signed divide works on magnitudes and re-applies the signs. This also
  // covers 0x8000_0000 / -1: magnitude quotient 0x8000_0000 negates to
  // itself and the remainder is zero.
  assign w_absA  = src0_i[31] ? (32'b0 - src0_i) : src0_i;
  assign w_absB  = w_divisor[31] ? (32'b0 - w_divisor) : w_divisor;
  assign w_magQ  = w_absA / w_absB;
  assign w_magR  = w_absA % w_absB;
  assign w_sQuot = (src0_i[31] ^ w_divisor[31]) ? (32'b0 - w_magQ) : w_magQ;
  assign w_sRem  = src0_i[31] ? (32'b0 - w_magR) : w_magR;
  assign w_uQuot = src0_i / w_divisor;
  assign w_uRem  = src0_i % w_divisor;

  // Result select. Single-word ops leave hi at zero; NOP and unused opcodes
  // fall through to all-zero so nothing undefined leaks downstream.
  always_comb begin
    w_result = 64'b0;
    case (aluop_i)
      ALUOP_ADD:   w_result = {32'b0, w_sum};
      ALUOP_SUB:   w_result = {32'b0, w_diff};
      ALUOP_SLT:   w_result = {63'b0, w_slt};
      ALUOP_SLTU:  w_result = {63'b0, w_sltu};
      ALUOP_AND:   w_result = {32'b0, src0_i & src1_i};
      ALUOP_NOR:   w_result = {32'b0, ~(src0_i | src1_i)};
      ALUOP_OR:    w_result = {32'b0, src0_i | src1_i};
      ALUOP_LUI:   w_result = {32'b0, src1_i[15:0], 16'h0000};
      ALUOP_SLL:   w_result = {32'b0, src1_i << w_shamt};
      ALUOP_SRL:   w_result = {32'b0, src1_i >> w_shamt};
      ALUOP_SRA:   w_result = {32'b0, w_sra};
      ALUOP_MULT:  w_result = w_sprod;
      ALUOP_MULTU: w_result = w_uprod;
      ALUOP_DIV:   w_result = w_divZero ? {src0_i, 32'hFFFF_FFFF} : {w_sRem, w_sQuot};
      ALUOP_DIVU:  w_result = w_divZero ? {src0_i, 32'hFFFF_FFFF} : {w_uRem, w_uQuot};
      ALUOP_NOP:   w_result = 64'b0;
      default:     w_result = 64'b0;
    endcase
  end

  assign aluout_o = w_result;
  assign zero_o   = (w_result[31:0] == 32'b0);

  // Registered copy for pipeline boundaries; captures every cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      aluout_r_o <= 64'b0;
      zero_r_o   <= 1'b0;
    end else begin
      aluout_r_o <= w_result;
      zero_r_o   <= zero_o;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
// Self-checking bench for alu. Expected results are queued when stimulus is
// driven and popped when the combinational output is sampled.
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk_i;
  logic        rst_n_i;
  logic [4:0]  aluop_i;
  logic [31:0] src0_i;
  logic [31:0] src1_i;
  logic [63:0] aluout_o;
  logic        zero_o;
  logic [63:0] aluout_r_o;
  logic        zero_r_o;

  typedef struct {
    string       tag;
    logic [63:0] result;
  } expect_t;

  expect_t scoreQ[$];
  int checkCount = 0;
  int errorCount = 0;

  alu dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .aluop_i    (aluop_i),
    .src0_i     (src0_i),
    .src1_i     (src1_i),
    .aluout_o   (aluout_o),
    .zero_o     (zero_o),
    .aluout_r_o (aluout_r_o),
    .zero_r_o   (zero_r_o)
  );

  // 10 ns clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one operation on the falling edge and queue its expected result.
  task automatic applyStimulus(input string tag, input logic [4:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expResult);
    expect_t e;
    @(negedge clk_i);
    aluop_i = op;
    src0_i  = a;
    src1_i  = b;
    e.tag    = tag;
    e.result = expResult;
    scoreQ.push_back(e);
  endtask

  // Sample the combinational output after settling and retire one entry.
  task automatic retireOne();
    expect_t e;
    #2;
    if (scoreQ.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = scoreQ.pop_front();
      checkOutput(e.tag, aluout_o, e.result);
      checkOutput({e.tag, "_zero"}, {63'b0, zero_o}, {63'b0, e.result[31:0] == 32'b0});
    end
  endtask

  task automatic runOp(input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expResult);
    applyStimulus(tag, op, a, b, expResult);
    retireOne();
  endtask

  // Independent reference for the randomised patterns.
  function automatic logic [63:0] model(input logic [4:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sp;
    case (op)
      5'd1:  model = {32'b0, a + b};
      5'd2:  model = {32'b0, a - b};
      5'd5:  model = {32'b0, a & b};
      5'd7:  model = {32'b0, a | b};
      5'd11: model = {32'b0, 32'($signed(b) >>> a[4:0])};
      5'd12: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        model = sp;
      end
      5'd13: model = 64'(a) * 64'(b);
      default: model = 64'b0;
    endcase
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rop;
    logic [4:0]  opList [7];

    opList = '{5'd1, 5'd2, 5'd5, 5'd7, 5'd11, 5'd12, 5'd13};
    rst_n_i = 1'b0;
    aluop_i = 5'd0;
    src0_i  = 32'b0;
    src1_i  = 32'b0;

    // Reset state of the registered copy
    @(posedge clk_i);
    #1;
    checkOutput("reset_aluout_r", aluout_r_o, 64'b0);
    checkOutput("reset_zero_r", {63'b0, zero_r_o}, 64'b0);

    // Combinational path works while reset is held
    runOp("sub_5_5",   5'd2, 32'd5, 32'd5, 64'd0);
    runOp("sub_7_3",   5'd2, 32'd7, 32'd3, 64'd4);
    runOp("add_wrap",  5'd1, 32'hFFFF_FFFF, 32'd1, 64'd0);
    runOp("slt",       5'd3, 32'hFFFF_FFFF, 32'd1, 64'd1);
    runOp("sltu",      5'd4, 32'hFFFF_FFFF, 32'd1, 64'd0);
    runOp("sra",       5'd11, 32'd4, 32'h8000_0000, 64'h0000_0000_F800_0000);
    runOp("srl",       5'd10, 32'd4, 32'h8000_0000, 64'h0000_0000_0800_0000);
    runOp("sll_mask",  5'd9, 32'h0000_0021, 32'd1, 64'd2);
    runOp("lui",       5'd8, 32'hDEAD_BEEF, 32'h0000_1234, 64'h0000_0000_1234_0000);
    runOp("mult",      5'd12, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    runOp("multu",     5'd13, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
    runOp("div_neg",   5'd14, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp("divu",      5'd15, 32'd7, 32'd2, {32'd1, 32'd3});
    runOp("divu_zero", 5'd15, 32'd9, 32'd0, {32'd9, 32'hFFFF_FFFF});
    runOp("div_zero",  5'd14, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    runOp("div_ovf",   5'd14, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    runOp("div_rem",   5'd14, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
    runOp("and",       5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_00F0_00F0);
    runOp("or",        5'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_FFF0_FFF0);
    runOp("nor",       5'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_000F_000F);
    runOp("nop",       5'd0, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
    runOp("op31",      5'd31, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
    runOp("op16",      5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);

    // Registered copies stay cleared across an edge while reset is low
    @(posedge clk_i);
    #1;
    checkOutput("held_aluout_r", aluout_r_o, 64'b0);
    checkOutput("held_zero_r", {63'b0, zero_r_o}, 64'b0);

    // Randomised patterns against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = opList[$urandom_range(6, 0)];
      ra  = $urandom;
      rb  = $urandom;
      runOp($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb));
    end

    // Register path: release reset, ADD 2+3, then one rising edge
    @(negedge clk_i);
    rst_n_i = 1'b1;
    runOp("reg_add", 5'd1, 32'd2, 32'd3, 64'd5);
    @(posedge clk_i);
    #1;
    checkOutput("reg_aluout_r", aluout_r_o, 64'd5);
    checkOutput("reg_zero_r", {63'b0, zero_r_o}, 64'd0);

    // Mid-cycle async reset clears the copies without a clock edge
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("async_aluout_r", aluout_r_o, 64'b0);
    checkOutput("async_zero_r", {63'b0, zero_r_o}, 64'b0);
    checkOutput("async_comb", aluout_o, 64'd5);

    // After release the zero flag copy follows a SUB that compares equal
    @(negedge clk_i);
    rst_n_i = 1'b1;
    runOp("reg_sub", 5'd2, 32'd9, 32'd9, 64'd0);
    @(posedge clk_i);
    #1;
    checkOutput("reg_sub_zero_r", {63'b0, zero_r_o}, 64'd1);
    checkOutput("reg_sub_aluout_r", aluout_r_o, 64'd0);

    checkOutput("scoreboard_drained", 64'(scoreQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
